fphub_add_issue_stage: RTL

Upstream issue stage for the FPHUB adder. It accepts operand pairs on a valid/ready stream and buffers them in a DEPTH-entry FIFO. Each pair is driven to the adder under a start/finish handshake, and the adder result is captured into a single-entry output register drained by a valid/ready consumer. It turns the adder's bare start/finish interface into a flow-controlled pipeline stage, and it works with both the single-cycle adder (finish tied high) and future multi-cycle adders.

---
 rtl/fphub_add_issue_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fphub_add_issue_stage.sv
// fphub_add_issue_stage
// Flow-controlled issue stage in front of the FPHUB adder. Operand pairs
// arrive on a valid/ready stream into a DEPTH-entry FIFO, one pair at a time
// is handed to the adder under a start/finish handshake, and the result is
// held in a single-entry output register for a valid/ready consumer.
//
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_ready     operand-pair stream; in_X, in_Y HUB operands
//   add_start/add_finish  adder handshake; add_X, add_Y operands, add_Z result
//   out_valid/out_ready   result stream; out_Z result
//   count                 FIFO occupancy (0..DEPTH)
//   busy                  high while an operation is in flight (EXEC)
module fphub_add_issue_stage #(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [E+M:0]             in_X,
  input  logic [E+M:0]             in_Y,
  output logic                     add_start,
  output logic [E+M:0]             add_X,
  output logic [E+M:0]             add_Y,
  input  logic                     add_finish,
  input  logic [E+M:0]             add_Z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [E+M:0]             out_Z,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int W  = E + M + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    fifo_x [DEPTH];
  logic [W-1:0]    fifo_y [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    op_x, op_y;
  logic [W-1:0]    z_q;
  logic            ov_q;
  logic            push, pop, capture;

  // Registered-state only, so acceptance never depends on a same-cycle pop.
  assign in_ready = (cnt < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (cnt != '0 && (!ov_q || out_ready)) begin
          state_nx = EXEC;
          pop      = 1'b1;
        end
      end
      EXEC: begin
        if (add_finish) begin
          state_nx = IDLE;
          capture  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Storage array carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr] <= in_X;
      fifo_y[wr_ptr] <= in_Y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_x <= '0;
      op_y <= '0;
    end else if (pop) begin
      op_x <= fifo_x[rd_ptr];
      op_y <= fifo_y[rd_ptr];
    end
  end

  // A capture on the same edge as a drain keeps the register full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q <= 1'b0;
      z_q  <= '0;
    end else if (capture) begin
      ov_q <= 1'b1;
      z_q  <= add_Z;
    end else if (ov_q && out_ready) begin
      ov_q <= 1'b0;
    end
  end

  assign add_start = (state == EXEC);
  assign busy      = (state == EXEC);
  assign add_X     = op_x;
  assign add_Y     = op_y;
  assign out_valid = ov_q;
  assign out_Z     = z_q;
  assign count     = cnt;

endmodule
